snitch_tcdm_bank_responder: RTL and testbench
=============================================

Name: snitch_tcdm_bank_responder

Overview:
- Multi-port, word-interleaved banked TCDM responder: the memory end of the narrow TCDM request/response channel that the HWPE subsystem drives as initiator, one per 64-bit lane.
- Accepts NrPorts independent q_valid/q_ready requests, arbitrates per bank (round-robin) and returns read data / write acks with fixed latency.
- Used as the HWPE-side scratchpad in standalone accelerator benches and as the reference responder for lane-skew testing (lanes granted in different cycles).

Parameters:
- NrPorts, 4, number of requesting TCDM ports.
- NrBanks, 8, number of SRAM banks; power of two, >= 1.
- WordsPerBank, 256, rows per bank; power of two.
- AddrWidth, 32, request byte-address width.
- DataWidth, 64, word width; power of two, >= 32.
- StrbWidth, DataWidth/8, byte-enable width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- q_valid_i  in  NrPorts  request valid per port.
- q_ready_o  out  NrPorts  request grant per port.
- q_addr_i  in  NrPorts x AddrWidth  byte address.
- q_write_i  in  NrPorts  1 = write, 0 = read.
- q_strb_i  in  NrPorts x StrbWidth  write byte enables.
- q_data_i  in  NrPorts x DataWidth  write data.
- p_valid_o  out  NrPorts  response valid per port.
- p_data_o  out  NrPorts x DataWidth  read data; '0 for write acks.

Behaviour:
- Decode: Off = log2(StrbWidth); bank = addr[Off +: log2(NrBanks)]; row = addr[Off+log2(NrBanks) +: log2(WordsPerBank)]. Upper address bits ignored, so out-of-range addresses alias (wrap). Low Off bits ignored.
- Grant: combinational. q_ready_o[p] = q_valid_i[p] and p wins its target bank this cycle. q_ready_o is never high without q_valid_i. The handshake completes when q_valid_i & q_ready_o are both high.
- Arbitration: one round-robin pointer per bank, reset to port 0.
  - Winner is the first requesting port at or after the pointer.
  - On a grant, the pointer moves to winner+1 mod NrPorts. With no grant it holds.
  - Ports targeting different banks are all granted in the same cycle.
- Access: exactly one access per bank per cycle.
  - Write: only bytes with strb=1 are updated, at the clock edge of the grant.
  - Read: returns the row contents as of before that edge.
  - Read in cycle N+1 of a row written in cycle N returns the new data.
- Response latency 1:
  - A grant in cycle N drives p_valid_o[p]=1 in cycle N+1 for exactly one cycle.
  - p_data_o[p] carries read data, or '0 for a write.
  - No p_ready: responses cannot be back-pressured.
  - A port may issue a new request every cycle; responses return in request order.
- Unstrobed write (strb='0): still granted and acked; memory unchanged.
- Requestor may change or drop a request while q_ready_o=0; no request state is held for it.
- Reset (async assert, sync deassert by the clock domain):
  - p_valid_o=0, p_data_o='0, all RR pointers = 0.
  - Memory contents are not reset.
  - Responses pending when reset asserts are dropped and never appear.
- Storage: NrBanks arrays of WordsPerBank x DataWidth flops/behavioural SRAM. Flip-flop arrays, no macro instantiation.
- Assertions:
  - NrBanks and WordsPerBank are powers of two.
  - Once raised, q_valid_i is not checked for stability (per the relaxed TCDM protocol).

Optional Feature:
- Macro: SNITCH_TCDM_RESP_OUTREG_EN.
- Defined: an extra register stage on p_valid_o/p_data_o; latency becomes 2 cycles. Grant logic is unchanged. Reset clears both stages.
- Undefined: latency 1 as above.

Test Plan:
- Single port, no conflict: write port0 addr 0x40 data 0xDEADBEEF_CAFEF00D strb 0xFF, then read 0x40 -> q_ready same cycle; read p_valid one cycle later with 0xDEADBEEF_CAFEF00D; write ack p_data '0.
- Partial strobe: preload 0x0 at addr 0x80; write 0x1122334455667788 with strb 0x0F; read -> 0x0000000055667788.
- Four ports, all to bank 0 (addrs 0x0, 0x40, 0x80, 0xC0), held valid -> exactly one grant per cycle, order p0,p1,p2,p3 over 4 cycles. Repeat -> order restarts at p0 (pointer wrapped), no starvation.
- Four ports, distinct banks (addrs 0x00, 0x08, 0x10, 0x18) -> all q_ready high in the same cycle; four p_valid next cycle.
- Wrap-around: write addr 0x0 then read addr 0x4000 (default params alias) -> same data returned.
- Reset mid-operation: assert rst_i the cycle after a read grant -> no p_valid that cycle or later; RR pointers back to 0.
- With SNITCH_TCDM_RESP_OUTREG_EN: same tests with p_valid at +2 cycles.

Source files
------------

// File: rtl/snitch_tcdm_bank_responder.sv
// snitch_tcdm_bank_responder
//
// Memory end of a narrow TCDM request/response channel. NrPorts initiators
// issue word requests into NrBanks word-interleaved flip-flop banks. Each bank
// serves one access per cycle and picks its winner with a per-bank round-robin
// pointer. Read data and write acks come back with a fixed latency. Responses
// cannot be back-pressured.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous, active-high reset
//   q_valid_i  [NrPorts]            request valid per port
//   q_ready_o  [NrPorts]            grant per port (combinational, implies q_valid_i)
//   q_addr_i   [NrPorts*AddrWidth]  byte address per port
//   q_write_i  [NrPorts]            1 = write, 0 = read
//   q_strb_i   [NrPorts*StrbWidth]  write byte enables per port
//   q_data_i   [NrPorts*DataWidth]  write data per port
//   p_valid_o  [NrPorts]            response valid per port (one cycle per grant)
//   p_data_o   [NrPorts*DataWidth]  read data, '0 for write acks
//
// Handshake: a request transfers in the cycle where q_valid_i[p] and
// q_ready_o[p] are both high. A requestor may change or drop a request while
// q_ready_o[p] is low; nothing is held for it, and q_valid_i is not checked
// for stability.
//
// Optional build macro SNITCH_TCDM_RESP_OUTREG_EN: adds a second register
// stage on p_valid_o/p_data_o, so the response latency becomes 2 cycles.
// Without it the latency is 1 cycle. Grant logic is the same in both builds.
//
// Debug visibility: the round-robin pointers (rr_ptr) and the per-bank winner
// (bank_any/bank_win) are plain named signals.

module snitch_tcdm_bank_responder #(
    parameter int unsigned NrPorts      = 4,
    parameter int unsigned NrBanks      = 8,
    parameter int unsigned WordsPerBank = 256,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts-1:0]             q_valid_i,
    output logic [NrPorts-1:0]             q_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]   q_addr_i,
    input  logic [NrPorts-1:0]             q_write_i,
    input  logic [NrPorts*StrbWidth-1:0]   q_strb_i,
    input  logic [NrPorts*DataWidth-1:0]   q_data_i,
    output logic [NrPorts-1:0]             p_valid_o,
    output logic [NrPorts*DataWidth-1:0]   p_data_o
);

    localparam int unsigned Off      = $clog2(StrbWidth);
    localparam int unsigned BankBits = $clog2(NrBanks);
    localparam int unsigned BankW    = (NrBanks > 1) ? BankBits : 1;
    localparam int unsigned RowW     = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;
    localparam int unsigned PtrW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    logic [BankW-1:0]     bank_idx [NrPorts];
    logic [RowW-1:0]      row_idx  [NrPorts];
    logic [NrBanks-1:0]   bank_any;
    logic [PtrW-1:0]      bank_win [NrBanks];
    logic [PtrW-1:0]      rr_ptr   [NrBanks];
    logic [DataWidth-1:0] mem      [NrBanks][WordsPerBank];

    logic [NrPorts-1:0]           resp_valid;
    logic [NrPorts*DataWidth-1:0] resp_data;

    // Address decode. Masking instead of slicing keeps NrBanks == 1 legal;
    // upper address bits are dropped, so out-of-range addresses wrap.
    always_comb begin
        logic [AddrWidth-1:0] word;
        word = '0;
        for (int p = 0; p < NrPorts; p++) begin
            word        = q_addr_i[p*AddrWidth +: AddrWidth] >> Off;
            bank_idx[p] = BankW'(word & AddrWidth'(NrBanks - 1));
            row_idx[p]  = RowW'((word >> BankBits) & AddrWidth'(WordsPerBank - 1));
        end
    end

    // Per-bank round robin: scan ports starting at the pointer, the first
    // valid port targeting this bank wins.
    always_comb begin
        int unsigned     cand;
        logic [PtrW-1:0] cand_p;
        cand   = 0;
        cand_p = '0;
        for (int b = 0; b < NrBanks; b++) begin
            bank_any[b] = 1'b0;
            bank_win[b] = '0;
            for (int k = 0; k < NrPorts; k++) begin
                cand = int'(rr_ptr[b]) + k;
                if (cand >= NrPorts) cand = cand - NrPorts;
                cand_p = PtrW'(cand);
                if (!bank_any[b] && q_valid_i[cand_p] &&
                    (bank_idx[cand_p] == BankW'(b))) begin
                    bank_any[b] = 1'b1;
                    bank_win[b] = cand_p;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            q_ready_o[p] = q_valid_i[p] && bank_any[bank_idx[p]] &&
                           (bank_win[bank_idx[p]] == PtrW'(p));
        end
    end

    // Pointers and first response stage. The read samples the row before the
    // same edge's write, which is the only access to that bank this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NrBanks; b++) rr_ptr[b] <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                if (bank_any[b]) begin
                    rr_ptr[b] <= (bank_win[b] == PtrW'(NrPorts - 1)) ? '0
                                                                     : bank_win[b] + PtrW'(1);
                end
            end
            resp_valid <= q_ready_o;
            for (int p = 0; p < NrPorts; p++) begin
                resp_data[p*DataWidth +: DataWidth] <= (q_ready_o[p] && !q_write_i[p])
                                                       ? mem[bank_idx[p]][row_idx[p]] : '0;
            end
        end
    end

    // Storage has no reset: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NrPorts; p++) begin
            if (q_ready_o[p] && q_write_i[p]) begin
                for (int i = 0; i < StrbWidth; i++) begin
                    if (q_strb_i[p*StrbWidth + i]) begin
                        mem[bank_idx[p]][row_idx[p]][8*i +: 8] <= q_data_i[p*DataWidth + 8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef SNITCH_TCDM_RESP_OUTREG_EN
    logic [NrPorts-1:0]           out_valid;
    logic [NrPorts*DataWidth-1:0] out_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= resp_valid;
            out_data  <= resp_data;
        end
    end

    assign p_valid_o = out_valid;
    assign p_data_o  = out_data;
`else
    assign p_valid_o = resp_valid;
    assign p_data_o  = resp_data;
`endif

    // Bank/row decode relies on power-of-two geometry.
    always @(posedge clk_i) begin
        assert ((NrBanks & (NrBanks - 1)) == 0);
        assert ((WordsPerBank & (WordsPerBank - 1)) == 0);
    end

endmodule

// File: tb/tb_snitch_tcdm_bank_responder.sv
// Testbench for snitch_tcdm_bank_responder (default parameters).
// Reference model: memory as an associative array indexed by the linear word
// number (byte address / 8, modulo the total word count), one round-robin
// pointer per bank, and a short history of per-cycle responses.

module tb_snitch_tcdm_bank_responder;

    localparam int NP  = 4;
    localparam int NB  = 8;
    localparam int WPB = 256;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int OFF = 3;
`ifdef SNITCH_TCDM_RESP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0]    q_valid;
    logic [NP-1:0]    q_ready;
    logic [NP*AW-1:0] q_addr;
    logic [NP-1:0]    q_write;
    logic [NP*SW-1:0] q_strb;
    logic [NP*DW-1:0] q_data;
    logic [NP-1:0]    p_valid;
    logic [NP*DW-1:0] p_data;

    snitch_tcdm_bank_responder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .q_valid_i (q_valid),
        .q_ready_o (q_ready),
        .q_addr_i  (q_addr),
        .q_write_i (q_write),
        .q_strb_i  (q_strb),
        .q_data_i  (q_data),
        .p_valid_o (p_valid),
        .p_data_o  (p_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0]    mdl_mem [int unsigned];
    int               rr  [NB];
    int               win [NB];
    logic [NP-1:0]    hv  [2];
    logic [NP*DW-1:0] hd  [2];
    logic [NP-1:0]    exp_ready;
    logic [NP-1:0]    exp_valid;
    logic [NP*DW-1:0] exp_data;

    function automatic int unsigned word_of(input logic [AW-1:0] a);
        return (a >> OFF) % (NB * WPB);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        for (int i = 0; i < 2; i++) begin
            hv[i] = '0;
            hd[i] = '0;
        end
    endtask

    // Expected grants for the current inputs and expected outputs now visible.
    task automatic model_eval();
        int best;
        int best_d;
        int d;
        exp_ready = '0;
        for (int b = 0; b < NB; b++) begin
            best   = -1;
            best_d = NP;
            for (int p = 0; p < NP; p++) begin
                if (q_valid[p] && (word_of(q_addr[p*AW +: AW]) % NB) == b) begin
                    d = (p - rr[b] + NP) % NP;
                    if (d < best_d) begin
                        best_d = d;
                        best   = p;
                    end
                end
            end
            win[b] = best;
            if (best >= 0) exp_ready[best] = 1'b1;
        end
        exp_valid = hv[LAT-1];
        exp_data  = hd[LAT-1];
    endtask

    // Apply the effect of the coming clock edge.
    task automatic model_commit();
        logic [NP-1:0]    nv;
        logic [NP*DW-1:0] nd;
        logic [DW-1:0]    cur;
        int unsigned      w;
        nv = '0;
        nd = '0;
        for (int p = 0; p < NP; p++) begin
            if (exp_ready[p]) begin
                nv[p] = 1'b1;
                w = word_of(q_addr[p*AW +: AW]);
                if (!q_write[p]) nd[p*DW +: DW] = mdl_mem.exists(w) ? mdl_mem[w] : '0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_ready[p] && q_write[p]) begin
                w   = word_of(q_addr[p*AW +: AW]);
                cur = mdl_mem.exists(w) ? mdl_mem[w] : '0;
                for (int i = 0; i < SW; i++)
                    if (q_strb[p*SW + i]) cur[8*i +: 8] = q_data[p*DW + 8*i +: 8];
                mdl_mem[w] = cur;
            end
        end
        for (int b = 0; b < NB; b++)
            if (win[b] >= 0) rr[b] = (win[b] + 1) % NP;
        hv[1] = hv[0];
        hd[1] = hd[0];
        hv[0] = nv;
        hd[0] = nd;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        q_valid = '0;
        q_addr  = '0;
        q_write = '0;
        q_strb  = '0;
        q_data  = '0;
    endtask

    task automatic set_port(input int p, input logic v, input logic [AW-1:0] a,
                            input logic w, input logic [SW-1:0] s, input logic [DW-1:0] d);
        q_valid[p]         = v;
        q_addr[p*AW +: AW] = a;
        q_write[p]         = w;
        q_strb[p*SW +: SW] = s;
        q_data[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (p_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_p_valid: got %b want 0", p_valid);
        end
        n_tests++;
        if (p_data !== '0) begin
            n_fail++;
            $display("FAIL reset_p_data: got %h want 0", p_data);
        end
        n_tests++;
        if (q_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_q_ready: got %b want 0", q_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        logic [DW-1:0] want;
        logic          has_want;
        for (int s = 0; s < 11; s++) begin
            idle_all();
            case (s)
                0: set_port(0, 1, 32'h40,   1, 8'hFF, 64'hDEADBEEF_CAFEF00D);
                1: set_port(0, 1, 32'h40,   0, 8'h00, 64'h0);
                2: set_port(0, 1, 32'h0,    1, 8'hFF, 64'h01234567_89ABCDEF);
                3: set_port(0, 1, 32'h4000, 0, 8'h00, 64'h0);
                4: set_port(0, 1, 32'h80,   1, 8'hFF, 64'h0);
                5: set_port(0, 1, 32'h80,   1, 8'h0F, 64'h11223344_55667788);
                6: set_port(0, 1, 32'h80,   0, 8'h00, 64'h0);
                default: ;
            endcase
            has_want = 1'b1;
            case (s - LAT)
                0: want = 64'h0;
                1: want = 64'hDEADBEEF_CAFEF00D;
                3: want = 64'h01234567_89ABCDEF;
                6: want = 64'h00000000_55667788;
                default: begin
                    want     = 64'h0;
                    has_want = 1'b0;
                end
            endcase
            model_eval();
            @(negedge clk);
            n_tests++;
            if (q_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL single_ready s%0d: got %b want %b", s, q_ready, exp_ready);
            end
            n_tests++;
            if (p_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL single_p_valid s%0d: got %b want %b", s, p_valid, exp_valid);
            end
            n_tests++;
            if (p_data !== exp_data) begin
                n_fail++;
                $display("FAIL single_p_data s%0d: got %h want %h", s, p_data, exp_data);
            end
            if (has_want) begin
                n_tests++;
                if (p_valid[0] !== 1'b1 || p_data[DW-1:0] !== want) begin
                    n_fail++;
                    $display("FAIL single_known s%0d: got v=%b d=%h want v=1 d=%h",
                             s, p_valid[0], p_data[DW-1:0], want);
                end
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_same_bank();
        logic [NP-1:0] onehot;
        do_reset();
        for (int s = 0; s < 11; s++) begin
            idle_all();
            if (s < 8) begin
                for (int p = 0; p < NP; p++)
                    set_port(p, 1, AW'(p * 32'h40), 1, 8'hFF, {32'hA5A50000 + p, 32'(s)});
            end
            model_eval();
            @(negedge clk);
            if (s < 8) begin
                onehot = NP'(1) << (s % NP);
                n_tests++;
                if (q_ready !== onehot) begin
                    n_fail++;
                    $display("FAIL same_bank_order s%0d: got %b want %b", s, q_ready, onehot);
                end
            end
            n_tests++;
            if (q_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL same_bank_ready s%0d: got %b want %b", s, q_ready, exp_ready);
            end
            n_tests++;
            if (p_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL same_bank_p_valid s%0d: got %b want %b", s, p_valid, exp_valid);
            end
            n_tests++;
            if (p_data !== exp_data) begin
                n_fail++;
                $display("FAIL same_bank_p_data s%0d: got %h want %h", s, p_data, exp_data);
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_distinct_banks();
        for (int s = 0; s < 6; s++) begin
            idle_all();
            if (s < 2) begin
                for (int p = 0; p < NP; p++)
                    set_port(p, 1, AW'(p * 8), (s == 0), 8'hFF, {32'h5EED0000 + p, 32'h0BAD0000 + p});
            end
            model_eval();
            @(negedge clk);
            if (s < 2) begin
                n_tests++;
                if (q_ready !== 4'hF) begin
                    n_fail++;
                    $display("FAIL distinct_all_ready s%0d: got %b want 1111", s, q_ready);
                end
            end
            if (s == LAT || s == LAT + 1) begin
                n_tests++;
                if (p_valid !== 4'hF) begin
                    n_fail++;
                    $display("FAIL distinct_all_valid s%0d: got %b want 1111", s, p_valid);
                end
            end
            n_tests++;
            if (q_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL distinct_ready s%0d: got %b want %b", s, q_ready, exp_ready);
            end
            n_tests++;
            if (p_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL distinct_p_valid s%0d: got %b want %b", s, p_valid, exp_valid);
            end
            n_tests++;
            if (p_data !== exp_data) begin
                n_fail++;
                $display("FAIL distinct_p_data s%0d: got %h want %h", s, p_data, exp_data);
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    // Random traffic over 32 preloaded words (every bank, rows 0..3), with
    // random upper address bits to exercise aliasing.
    task automatic test_random();
        int unsigned   widx;
        logic [AW-1:0] a;
        for (int s = 0; s < 32 + 400 + 3; s++) begin
            idle_all();
            if (s < 32) begin
                set_port(0, 1, AW'(s * 8), 1, 8'hFF, {$urandom, $urandom});
            end else if (s < 432) begin
                for (int p = 0; p < NP; p++) begin
                    widx = $urandom_range(0, 31);
                    a    = ($urandom & 32'hFFFF_C000) | (widx << 3) | $urandom_range(0, 7);
                    set_port(p, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                             8'($urandom), {$urandom, $urandom});
                end
            end
            model_eval();
            @(negedge clk);
            n_tests++;
            if (q_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL random_ready s%0d: got %b want %b", s, q_ready, exp_ready);
            end
            n_tests++;
            if (p_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL random_p_valid s%0d: got %b want %b", s, p_valid, exp_valid);
            end
            n_tests++;
            if (p_data !== exp_data) begin
                n_fail++;
                $display("FAIL random_p_data s%0d: got %h want %h", s, p_data, exp_data);
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 9; s++) begin
            idle_all();
            case (s)
                2: set_port(0, 1, 32'h0, 0, 8'h00, 64'h0);
                3: begin
                    rst = 1'b1;
                    model_reset();
                end
                5: begin
                    rst = 1'b0;
                    set_port(0, 1, 32'h0,  0, 8'h00, 64'h0);
                    set_port(1, 1, 32'h40, 0, 8'h00, 64'h0);
                end
                default: ;
            endcase
            model_eval();
            @(negedge clk);
            if (s >= 3 && s <= 5) begin
                n_tests++;
                if (p_valid !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_dropped s%0d: got %b want 0", s, p_valid);
                end
            end
            if (s == 5) begin
                n_tests++;
                if (q_ready !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL reset_mid_rr s%0d: got %b want 0001", s, q_ready);
                end
            end
            n_tests++;
            if (q_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL reset_mid_ready s%0d: got %b want %b", s, q_ready, exp_ready);
            end
            n_tests++;
            if (p_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL reset_mid_p_valid s%0d: got %b want %b", s, p_valid, exp_valid);
            end
            n_tests++;
            if (p_data !== exp_data) begin
                n_fail++;
                $display("FAIL reset_mid_p_data s%0d: got %h want %h", s, p_data, exp_data);
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        idle_all();
        model_reset();
        test_reset();
        test_single_port();
        test_same_bank();
        test_distinct_banks();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
